// File: rtl/io_out_chunk_tx_pkg.sv
// Shared pin positions, default geometry and FSM state type for the chunked result transmitter.
package io_out_chunk_tx_pkg;

  // Positions on io_out: the marker is bit 0 and chunk data starts at bit 1.
  localparam int unsigned OMarkBitId  = 0;
  localparam int unsigned OChunkBitId = 1;

  localparam int unsigned DefaultWidth  = 7;
  localparam int unsigned DefaultChunks = 2;
  localparam int unsigned DefaultGap    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } tx_state_e;

endpackage

// File: rtl/io_out_chunk_tx.sv
// Latches one wide result via valid/ready and streams it LSB-chunk first over CHUNKS clocks,
// with a frame marker on pin 0 during chunk 0.
module io_out_chunk_tx
  import io_out_chunk_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned CHUNKS     = DefaultChunks,
  parameter int unsigned GAP_CYCLES = DefaultGap
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*CHUNKS-1:0]  in_data,
  output logic [WIDTH:0]           out_pins,
  output logic                     busy
);

  localparam int unsigned DW    = WIDTH * CHUNKS;
  localparam int unsigned CntW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned GcntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(CHUNKS - 1);
  localparam logic [GcntW-1:0] GcntLast = GcntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e        state_q, state_d;
  logic [DW-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GcntW-1:0] gcnt_q, gcnt_d;
  logic [WIDTH:0]   out_pins_q, out_pins_d;

  logic last_chunk;
  logic accept;

  assign last_chunk = (cnt_q == CntLast);

  // A new frame may start on the last chunk only when no gap is enforced.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle:  in_ready = 1'b1;
        StSend:  in_ready = last_chunk && (GAP_CYCLES == 0);
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state logic computes the pin value for the coming cycle so out_pins stays registered.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    out_pins_d = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d                              = StSend;
          shreg_d                              = in_data >> WIDTH;
          cnt_d                                = '0;
          out_pins_d[OMarkBitId]               = 1'b1;
          out_pins_d[OChunkBitId +: WIDTH]     = in_data[WIDTH-1:0];
        end
      end

      StSend: begin
        if (!last_chunk) begin
          cnt_d                                = cnt_q + 1'b1;
          shreg_d                              = shreg_q >> WIDTH;
          out_pins_d[OChunkBitId +: WIDTH]     = shreg_q[WIDTH-1:0];
        end else if (GAP_CYCLES > 0) begin
          state_d = StGap;
          gcnt_d  = '0;
          cnt_d   = '0;
        end else if (accept) begin
          state_d                              = StSend;
          shreg_d                              = in_data >> WIDTH;
          cnt_d                                = '0;
          out_pins_d[OMarkBitId]               = 1'b1;
          out_pins_d[OChunkBitId +: WIDTH]     = in_data[WIDTH-1:0];
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      StGap: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GcntLast) begin
          state_d = StIdle;
          gcnt_d  = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      out_pins_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      out_pins_q <= out_pins_d;
    end
  end

  assign out_pins = out_pins_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_io_out_chunk_tx.sv
// Scoreboard bench for io_out_chunk_tx: three instances (gap 0, gap 2, single chunk).
module tb_io_out_chunk_tx;

  typedef struct {
    logic [7:0] pins;
    logic       ready;
    logic       busy;
    int         tag;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic valid_a, valid_b, valid_c;
  logic ready_a, ready_b, ready_c;
  logic [13:0] data_a, data_b;
  logic [6:0]  data_c;
  logic [7:0]  pins_a, pins_b, pins_c;
  logic busy_a, busy_b, busy_c;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   tag;
  bit   done;
  int   errors;
  int   checks;

  io_out_chunk_tx #(.WIDTH(7), .CHUNKS(2), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_data(data_a), .out_pins(pins_a), .busy(busy_a)
  );

  io_out_chunk_tx #(.WIDTH(7), .CHUNKS(2), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_data(data_b), .out_pins(pins_b), .busy(busy_b)
  );

  io_out_chunk_tx #(.WIDTH(7), .CHUNKS(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst_n(rst_c), .in_valid(valid_c), .in_ready(ready_c),
    .in_data(data_c), .out_pins(pins_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int t, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, t, act, exp);
    end
  endtask

  // Monitor: every cycle with a queued expectation, compare the DUT view at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_pins", e.tag, pins_a, e.pins);
      chk("a_ready", e.tag, {7'd0, ready_a}, {7'd0, e.ready});
      chk("a_busy", e.tag, {7'd0, busy_a}, {7'd0, e.busy});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_pins", e.tag, pins_b, e.pins);
      chk("b_ready", e.tag, {7'd0, ready_b}, {7'd0, e.ready});
      chk("b_busy", e.tag, {7'd0, busy_b}, {7'd0, e.busy});
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      chk("c_pins", e.tag, pins_c, e.pins);
      chk("c_ready", e.tag, {7'd0, ready_c}, {7'd0, e.ready});
      chk("c_busy", e.tag, {7'd0, busy_c}, {7'd0, e.busy});
    end
    if (done) begin
      chk("queues_drained", 0, 8'(qa.size() + qb.size() + qc.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Each step drives one cycle of inputs and queues what that cycle must show.
  task automatic step_a(input logic r, input logic v, input logic [13:0] d,
                        input logic [7:0] p, input logic rd, input logic b);
    rst_a = r; valid_a = v; data_a = d;
    qa.push_back('{pins: p, ready: rd, busy: b, tag: tag});
    tag++;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [13:0] d,
                        input logic [7:0] p, input logic rd, input logic b);
    valid_b = v; data_b = d;
    qb.push_back('{pins: p, ready: rd, busy: b, tag: tag});
    tag++;
    @(posedge clk); #1;
  endtask

  task automatic step_c(input logic v, input logic [6:0] d,
                        input logic [7:0] p, input logic rd, input logic b);
    valid_c = v; data_c = d;
    qc.push_back('{pins: p, ready: rd, busy: b, tag: tag});
    tag++;
    @(posedge clk); #1;
  endtask

  initial begin
    tag = 0; done = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    valid_a = 1'b1; valid_b = 1'b0; valid_c = 1'b0;
    data_a = 14'h2A5B; data_b = '0; data_c = '0;
    @(posedge clk); #1;

    // Reset held with valid asserted, then release.
    step_a(1'b0, 1'b1, 14'h2A5B, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 14'h2A5B, 8'h00, 1'b0, 1'b0);
    rst_b = 1'b1; rst_c = 1'b1;
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);

    // Single frame 0x2A5B.
    step_a(1'b1, 1'b1, 14'h2A5B, 8'h00, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 14'h0000, 8'hB7, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'hA8, 1'b1, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);

    // Back-to-back frames; valid during chunk0 must be ignored.
    step_a(1'b1, 1'b1, 14'h3FFF, 8'h00, 1'b1, 1'b0);
    step_a(1'b1, 1'b1, 14'h0001, 8'hFF, 1'b0, 1'b1);
    step_a(1'b1, 1'b1, 14'h0001, 8'hFE, 1'b1, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h03, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);

    // Reset during chunk0 abandons the frame, then a clean frame.
    step_a(1'b1, 1'b1, 14'h2A5B, 8'h00, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 14'h0000, 8'hB7, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);
    step_a(1'b1, 1'b1, 14'h2A5B, 8'h00, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 14'h0000, 8'hB7, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'hA8, 1'b1, 1'b1);
    step_a(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);

    // Two-cycle gap between frames under continuous valid.
    step_b(1'b1, 14'h3FFF, 8'h00, 1'b1, 1'b0);
    step_b(1'b1, 14'h0001, 8'hFF, 1'b0, 1'b1);
    step_b(1'b1, 14'h0001, 8'hFE, 1'b0, 1'b1);
    step_b(1'b1, 14'h0001, 8'h00, 1'b0, 1'b1);
    step_b(1'b1, 14'h0001, 8'h00, 1'b0, 1'b1);
    step_b(1'b1, 14'h0001, 8'h00, 1'b1, 1'b0);
    step_b(1'b0, 14'h0000, 8'h03, 1'b0, 1'b1);
    step_b(1'b0, 14'h0000, 8'h00, 1'b0, 1'b1);
    step_b(1'b0, 14'h0000, 8'h00, 1'b0, 1'b1);
    step_b(1'b0, 14'h0000, 8'h00, 1'b0, 1'b1);
    step_b(1'b0, 14'h0000, 8'h00, 1'b1, 1'b0);

    // Single-chunk frames: marker on every data cycle, ready throughout.
    step_c(1'b1, 7'h55, 8'h00, 1'b1, 1'b0);
    step_c(1'b1, 7'h2A, 8'hAB, 1'b1, 1'b1);
    step_c(1'b0, 7'h00, 8'h55, 1'b1, 1'b1);
    step_c(1'b0, 7'h00, 8'h00, 1'b1, 1'b0);

    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
